// File: rtl/status_vector_push_arbiter_if.sv
// Requester-side and vector-side signals of the status vector push arbiter.
// The arbiter takes the slave modport; the requesters/vector side take the master modport.
interface status_vector_push_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8
);
    localparam int LW = $clog2(DEPTH + 1);

    // Valid/ready semantics: a push is transferred on every edge where push_o is high
    // (the vector always accepts it, since the arbiter never offers a push the vector
    // cannot hold); gnt_o is the per-requester acknowledge of the same transfer.
    logic [NUM_REQ-1:0]       req_i;
    logic [NUM_REQ*WIDTH-1:0] req_value_i;
    logic [NUM_REQ-1:0]       set_req_i;
    logic [NUM_REQ*WIDTH-1:0] set_req_value_i;
    logic                     pull_i;
    logic [NUM_REQ-1:0]       gnt_o;
    logic                     push_o;
    logic [WIDTH-1:0]         value_o;
    logic                     set_o;
    logic [WIDTH-1:0]         set_value_o;
    logic                     set_err_o;
    logic [LW-1:0]            level_o;
    logic                     full_o;

    modport slave (
        input  req_i, req_value_i, set_req_i, set_req_value_i, pull_i,
        output gnt_o, push_o, value_o, set_o, set_value_o, set_err_o, level_o, full_o
    );

    modport master (
        output req_i, req_value_i, set_req_i, set_req_value_i, pull_i,
        input  gnt_o, push_o, value_o, set_o, set_value_o, set_err_o, level_o, full_o
    );
endinterface

// File: rtl/status_vector_push_arbiter.sv
// Round-robin push arbiter in front of a status value vector, with a shadow occupancy
// count and owner tracking so a set only updates the newest entry from its producer.
module status_vector_push_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8
) (
    input logic                          clk_i,
    input logic                          rsn_i,
    status_vector_push_arbiter_if.slave  bus
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               push_q, push_d;
    logic [WIDTH-1:0]   value_q, value_d;
    logic               set_q, set_d;
    logic [WIDTH-1:0]   set_value_q, set_value_d;
    logic               set_err_q, set_err_d;
    logic [LW-1:0]      level_q, level_d;
    logic               full_q, full_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]      last_owner_q, last_owner_d;
    logic               last_valid_q, last_valid_d;

    logic               pull_eff;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] accept_mask;
    logic               set_accept;
    logic               found;
    logic [PW-1:0]      win;
    logic [PW-1:0]      idx_v;
    logic               grant;

    always_comb begin
        pull_eff     = bus.pull_i && (level_q != '0);
        // A pull on an empty vector is ignored even when a push lands at the same edge.
        level_d      = level_q + LW'(push_q) - LW'(pull_eff);
        eligible     = bus.req_i & ~gnt_q;

        found = 1'b0;
        win   = '0;
        idx_v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_v = PW'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!found && eligible[idx_v]) begin
                found = 1'b1;
                win   = idx_v;
            end
        end

        accept_mask = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            accept_mask[k] = bus.set_req_i[k] && last_valid_q &&
                             (last_owner_q == PW'(k)) && (level_d != '0);
        end
        set_accept = |accept_mask;
        set_err_d  = |(bus.set_req_i & ~accept_mask);

        grant = found && (level_d < LW'(DEPTH)) && !set_accept;

        gnt_d        = '0;
        push_d       = 1'b0;
        value_d      = value_q;
        rr_ptr_d     = rr_ptr_q;
        last_owner_d = last_owner_q;
        last_valid_d = last_valid_q;
        set_d        = set_accept;
        set_value_d  = set_value_q;

        if (set_accept) begin
            set_value_d = bus.set_req_value_i[last_owner_q*WIDTH +: WIDTH];
        end

        if (grant) begin
            gnt_d        = NUM_REQ'(1) << win;
            push_d       = 1'b1;
            value_d      = bus.req_value_i[win*WIDTH +: WIDTH];
            rr_ptr_d     = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            last_owner_d = win;
            last_valid_d = 1'b1;
        end else if (level_d == '0) begin
            last_valid_d = 1'b0;
        end

        full_d = (level_d == LW'(DEPTH));
    end

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            gnt_q        <= '0;
            push_q       <= 1'b0;
            value_q      <= '0;
            set_q        <= 1'b0;
            set_value_q  <= '0;
            set_err_q    <= 1'b0;
            level_q      <= '0;
            full_q       <= 1'b0;
            rr_ptr_q     <= '0;
            last_owner_q <= '0;
            last_valid_q <= 1'b0;
        end else begin
            gnt_q        <= gnt_d;
            push_q       <= push_d;
            value_q      <= value_d;
            set_q        <= set_d;
            set_value_q  <= set_value_d;
            set_err_q    <= set_err_d;
            level_q      <= level_d;
            full_q       <= full_d;
            rr_ptr_q     <= rr_ptr_d;
            last_owner_q <= last_owner_d;
            last_valid_q <= last_valid_d;
        end
    end

    assign bus.gnt_o       = gnt_q;
    assign bus.push_o      = push_q;
    assign bus.value_o     = value_q;
    assign bus.set_o       = set_q;
    assign bus.set_value_o = set_value_q;
    assign bus.set_err_o   = set_err_q;
    assign bus.level_o     = level_q;
    assign bus.full_o      = full_q;
endmodule

// File: tb/tb_status_vector_push_arbiter.sv
// Directed bench for the status vector push arbiter (NUM_REQ=4, WIDTH=8, DEPTH=4).
module tb_status_vector_push_arbiter;
    logic clk;
    logic rsn;
    int   n_checks;
    int   n_pass;

    status_vector_push_arbiter_if #(.NUM_REQ(4), .WIDTH(8), .DEPTH(4)) bus ();

    status_vector_push_arbiter #(.NUM_REQ(4), .WIDTH(8), .DEPTH(4)) dut (
        .clk_i (clk),
        .rsn_i (rsn),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_out(input string tag, input logic [3:0] gnt, input logic push,
                             input logic [7:0] value, input logic [2:0] level, input logic full);
        check({tag, ".gnt"},   32'(bus.gnt_o),   32'(gnt));
        check({tag, ".push"},  32'(bus.push_o),  32'(push));
        check({tag, ".value"}, 32'(bus.value_o), 32'(value));
        check({tag, ".level"}, 32'(bus.level_o), 32'(level));
        check({tag, ".full"},  32'(bus.full_o),  32'(full));
    endtask

    task automatic check_set(input string tag, input logic set, input logic [7:0] set_value,
                             input logic err);
        check({tag, ".set"},       32'(bus.set_o),       32'(set));
        check({tag, ".set_value"}, 32'(bus.set_value_o), 32'(set_value));
        check({tag, ".set_err"},   32'(bus.set_err_o),   32'(err));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rsn                 = 1'b0;
        bus.req_i           = '0;
        bus.req_value_i     = '0;
        bus.set_req_i       = '0;
        bus.set_req_value_i = '0;
        bus.pull_i          = 1'b0;
        tick();
        tick();
        check_out("reset", 4'b0000, 1'b0, 8'h00, 3'd0, 1'b0);
        check_set("reset", 1'b0, 8'h00, 1'b0);

        // All four requesting: round-robin fill, one pull at empty is ignored.
        rsn             = 1'b1;
        bus.req_i       = 4'b1111;
        bus.req_value_i = 32'hD3C2B1A0;
        tick(); check_out("rr0", 4'b0001, 1'b1, 8'hA0, 3'd0, 1'b0);
        bus.pull_i = 1'b1;
        tick(); check_out("rr1_pull_at_empty", 4'b0010, 1'b1, 8'hB1, 3'd1, 1'b0);
        bus.pull_i = 1'b0;
        tick(); check_out("rr2", 4'b0100, 1'b1, 8'hC2, 3'd2, 1'b0);
        tick(); check_out("rr3", 4'b1000, 1'b1, 8'hD3, 3'd3, 1'b0);
        tick(); check_out("fill", 4'b0000, 1'b0, 8'hD3, 3'd4, 1'b1);
        tick(); check_out("full_hold", 4'b0000, 1'b0, 8'hD3, 3'd4, 1'b1);

        // One pull from full frees exactly one slot.
        bus.req_i  = 4'b0001;
        bus.pull_i = 1'b1;
        tick(); check_out("pull_from_full", 4'b0001, 1'b1, 8'hA0, 3'd3, 1'b0);
        bus.pull_i = 1'b0;
        tick(); check_out("refill", 4'b0000, 1'b0, 8'hA0, 3'd4, 1'b1);
        tick(); check_out("full_no_push", 4'b0000, 1'b0, 8'hA0, 3'd4, 1'b1);

        // Drain, then a set with no valid newest entry is dropped.
        bus.req_i  = 4'b0000;
        bus.pull_i = 1'b1;
        tick(); tick(); tick(); tick();
        check_out("drained", 4'b0000, 1'b0, 8'hA0, 3'd0, 1'b0);
        bus.pull_i          = 1'b0;
        bus.set_req_i       = 4'b0001;
        bus.set_req_value_i = 32'h000000EE;
        tick(); check_set("set_on_empty", 1'b0, 8'h00, 1'b1);
        bus.set_req_i = 4'b0000;
        tick(); check_set("err_pulse_end", 1'b0, 8'h00, 1'b0);

        // Single requester held high: grants alternate.
        bus.req_i = 4'b0100;
        tick(); check_out("single_on", 4'b0100, 1'b1, 8'hC2, 3'd0, 1'b0);
        tick(); check_out("single_off", 4'b0000, 1'b0, 8'hC2, 3'd1, 1'b0);
        tick(); check_out("single_on2", 4'b0100, 1'b1, 8'hC2, 3'd1, 1'b0);
        tick(); check_out("single_off2", 4'b0000, 1'b0, 8'hC2, 3'd2, 1'b0);

        // Owner push, accepted set with a pending push, then wrong-owner set.
        bus.req_i       = 4'b0010;
        bus.req_value_i = 32'h77C255A0;
        tick(); check_out("owner_push", 4'b0010, 1'b1, 8'h55, 3'd2, 1'b0);
        bus.req_i           = 4'b1000;
        bus.set_req_i       = 4'b0010;
        bus.set_req_value_i = 32'h0000AA00;
        tick();
        check_out("set_priority", 4'b0000, 1'b0, 8'h55, 3'd3, 1'b0);
        check_set("set_ok", 1'b1, 8'hAA, 1'b0);
        bus.set_req_i       = 4'b1000;
        bus.set_req_value_i = 32'hBB00AA00;
        tick();
        check_out("push_after_set", 4'b1000, 1'b1, 8'h77, 3'd3, 1'b0);
        check_set("set_wrong_owner", 1'b0, 8'hAA, 1'b1);
        bus.set_req_i = 4'b0000;
        bus.req_i     = 4'b0000;
        tick();
        check_out("full_again", 4'b0000, 1'b0, 8'h77, 3'd4, 1'b1);
        check_set("idle", 1'b0, 8'hAA, 1'b0);

        // Reset in the middle of a burst restarts arbitration at requester 0.
        bus.req_i       = 4'b1111;
        bus.req_value_i = 32'hD3C2B1A0;
        bus.pull_i      = 1'b1;
        tick(); check_out("burst0", 4'b0001, 1'b1, 8'hA0, 3'd3, 1'b0);
        tick(); check_out("burst1", 4'b0010, 1'b1, 8'hB1, 3'd3, 1'b0);
        rsn = 1'b0;
        tick();
        check_out("mid_reset", 4'b0000, 1'b0, 8'h00, 3'd0, 1'b0);
        check_set("mid_reset", 1'b0, 8'h00, 1'b0);
        rsn        = 1'b1;
        bus.pull_i = 1'b0;
        tick(); check_out("post_reset", 4'b0001, 1'b1, 8'hA0, 3'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
